// File: rtl/data_mem_arbiter.sv
// Round-robin req/ack arbiter sharing one single-port data memory between two requesters.
// One access per three cycles (IDLE -> ACCESS -> DONE); read data is returned registered.
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wena,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              pick_s;

  // Next-state, grant selection and registered-output updates
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    pick_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie the port that was not granted last wins; a lone requester always wins.
          if (p0_req && p1_req) begin
            pick_s = ~last_q;
          end else begin
            pick_s = p1_req;
          end
          gnt_d   = pick_s;
          last_d  = pick_s;
          we_d    = pick_s ? p1_we    : p0_we;
          addr_d  = pick_s ? p1_addr  : p0_addr;
          wdata_d = pick_s ? p1_wdata : p0_wdata;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        rdata0_d = (!we_q && !gnt_q) ? mem_rdata : rdata0_q;
        rdata1_d = (!we_q &&  gnt_q) ? mem_rdata : rdata1_q;
        ack0_d   = ~gnt_q;
        ack1_d   = gnt_q;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wena  = (state_q == ACCESS) && we_q;
  assign busy      = (state_q == ACCESS) || (state_q == DONE);
  assign p0_ack    = ack0_q;
  assign p1_ack    = ack1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level schedule model of the arbiter.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack, mem_wena, busy;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] env_mem [0:127];
  logic [31:0] m_mem   [0:127];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: one outstanding grant described by its grant cycle.
  bit          have_gnt, g_port, g_we, last, in_acc, in_done, pick;
  int          g_cyc, free_at;
  logic [31:0] g_addr, g_wdata, e_addr, e_wdata;
  logic [31:0] e_rd [0:1];
  bit          done_flag [0:1];

  data_mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wena(mem_wena),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = env_mem[mem_addr[6:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 1) begin
      p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      have_gnt = 1'b0; last = 1'b1; free_at = 0;
      e_addr = 32'd0; e_wdata = 32'd0; e_rd[0] = 32'd0; e_rd[1] = 32'd0;
      done_flag[0] = 1'b0; done_flag[1] = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wena", 32'(mem_wena), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_ack0", 32'(p0_ack), 32'd0);
      check("rst_ack1", 32'(p1_ack), 32'd0);
      check("rst_rd0", p0_rdata, 32'd0);
      check("rst_rd1", p1_rdata, 32'd0);
    end else begin
      in_acc  = have_gnt && (cyc == g_cyc + 1);
      in_done = have_gnt && (cyc == g_cyc + 2);
      check("busy", 32'(busy), 32'(in_acc || in_done));
      check("wena", 32'(mem_wena), 32'(in_acc && g_we));
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("ack0", 32'(p0_ack), 32'(in_done && !g_port));
      check("ack1", 32'(p1_ack), 32'(in_done && g_port));
      check("rdata0", p0_rdata, e_rd[0]);
      check("rdata1", p1_rdata, e_rd[1]);
      if (have_gnt && cyc <= g_cyc + 1)
        check("req_held", 32'(g_port ? p1_req : p0_req), 32'd1);
      done_flag[0] = in_done && !g_port;
      done_flag[1] = in_done && g_port;
      // The memory write and the read capture both land at the edge ending ACCESS.
      if (in_acc) begin
        if (g_we) begin
          m_mem[g_addr[6:0]] = g_wdata;
          if (mem_wena) env_mem[mem_addr[6:0]] = mem_wdata;
        end else begin
          e_rd[g_port] = m_mem[g_addr[6:0]];
        end
      end
      if (cyc >= free_at && (p0_req || p1_req)) begin
        pick    = (p0_req && p1_req) ? !last : p1_req;
        last    = pick;
        g_port  = pick;
        g_cyc   = cyc;
        free_at = cyc + 3;
        have_gnt = 1'b1;
        g_we    = pick ? p1_we : p0_we;
        g_addr  = pick ? p1_addr : p0_addr;
        g_wdata = pick ? p1_wdata : p0_wdata;
        e_addr  = g_addr;
        e_wdata = g_wdata;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Single transaction from an idle arbiter: ACCESS in cycle 1, ack in cycle 2.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    set_req(p, 1'b1, we, a, d);
    step(1);
    check("txn_wena", 32'(mem_wena), 32'(we));
    check("txn_addr", mem_addr, a);
    step(1);
    check("txn_ack", 32'(p == 1 ? p1_ack : p0_ack), 32'd1);
    check("txn_other_ack", 32'(p == 1 ? p0_ack : p1_ack), 32'd0);
    set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
  endtask

  logic        r_we;
  logic [31:0] r_addr, r_data;

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 128; i++) begin
      env_mem[i] = 32'hC0DE_0000 + i;
      m_mem[i]   = 32'hC0DE_0000 + i;
    end
    env_mem[7'h10] = 32'hDEAD_BEEF; m_mem[7'h10] = 32'hDEAD_BEEF;
    env_mem[7'h40] = 32'h0000_1111; m_mem[7'h40] = 32'h0000_1111;
    for (int i = 0; i < 4; i++) begin
      env_mem[7'h50 + i] = 32'hA5A5_0000 + i;
      m_mem[7'h50 + i]   = 32'hA5A5_0000 + i;
    end
    step(3);
    rst_n = 1'b1;

    txn(0, 1'b0, 32'h10, 32'd0);
    check("single_rd_data", p0_rdata, 32'hDEAD_BEEF);
    check("single_rd_p1", p1_rdata, 32'd0);

    txn(1, 1'b1, 32'h20, 32'h1234_5678);
    txn(1, 1'b0, 32'h20, 32'd0);
    check("wr_readback", p1_rdata, 32'h1234_5678);

    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b1, 1'b0, 32'h4, 32'd0);
      set_req(1, 1'b1, 1'b0, 32'h8, 32'd0);
      step(2);
      check("tie_p0_ack", 32'(p0_ack), 32'd1);
      check("tie_p1_wait", 32'(p1_ack), 32'd0);
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(3);
      check("tie_p1_ack", 32'(p1_ack), 32'd1);
      check("tie_p0_data", p0_rdata, 32'hC0DE_0004);
      check("tie_p1_data", p1_rdata, 32'hC0DE_0008);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1);
    end

    set_req(0, 1'b1, 1'b0, 32'h50, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(2);
      check("cont_ack", 32'(p0_ack), 32'd1);
      check("cont_data", p0_rdata, 32'hA5A5_0000 + i);
      if (i < 3) set_req(0, 1'b1, 1'b0, 32'h51 + i, 32'd0);
      else       set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1);
      check("cont_busy_low", 32'(busy), 32'd0);
    end

    set_req(0, 1'b1, 1'b1, 32'h30, 32'hAAAA_5555);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wena", 32'(mem_wena), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_ack", 32'(p0_ack), 32'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(2);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h4, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'h8, 32'd0);
    step(2);
    check("postrst_tie_p0", 32'(p0_ack), 32'd1);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(3);
    check("postrst_tie_p1", 32'(p1_ack), 32'd1);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1);

    txn(0, 1'b0, 32'h40, 32'd0);
    txn(0, 1'b1, 32'h44, 32'h9999_9999);
    check("wr_keeps_rdata", p0_rdata, 32'h0000_1111);

    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(p == 1 ? p1_req : p0_req) || done_flag[p]) begin
          r_we   = 1'($urandom_range(0, 1));
          r_addr = 32'($urandom_range(0, 15));
          r_data = $urandom();
          if ($urandom_range(0, 99) < 60) set_req(p, 1'b1, r_we, r_addr, r_data);
          else                            set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
      step(1);
    end
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 2; p++)
        if (done_flag[p]) set_req(p, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
